// File: rtl/sprite_draw_engine_pkg.sv
// Shared constants, state encoding and request payload for the sprite draw engine.
package sprite_draw_engine_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned COLOR_W  = 3;
  localparam int unsigned XS_W     = X_W + 1;
  localparam int unsigned YS_W     = Y_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } draw_state_e;

  typedef struct packed {
    logic [X_W-1:0] x0;
    logic [Y_W-1:0] y0;
    logic [X_W-1:0] w;
    logic [Y_W-1:0] h;
    logic           black;
  } draw_req_t;

  // Sums carry one extra bit so a wrap past X_W/Y_W bits is still seen as off-screen.
  function automatic logic on_screen(input logic [XS_W-1:0] x, input logic [YS_W-1:0] y);
    return (x < XS_W'(SCREEN_W)) && (y < YS_W'(SCREEN_H));
  endfunction

endpackage

// File: rtl/sprite_draw_engine_rect_scan_counter.sv
// Row-major col/row/linear-address counters for one rectangle, with a last-pixel flag.
module rect_scan_counter
  import sprite_draw_engine_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              step_i,
  input  logic [X_W-1:0]    w_i,
  input  logic [Y_W-1:0]    h_i,
  output logic [X_W-1:0]    col_o,
  output logic [Y_W-1:0]    row_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_c_o
);

  logic [X_W-1:0]    col_q, col_d;
  logic [Y_W-1:0]    row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              col_wrap_c;

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    addr_d     = addr_q;
    col_wrap_c = (col_q == (w_i - X_W'(1)));
    if (clear_i) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (step_i) begin
      addr_d = addr_q + ADDR_W'(1);
      if (col_wrap_c) begin
        col_d = '0;
        row_d = row_q + Y_W'(1);
      end else begin
        col_d = col_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign col_o    = col_q;
  assign row_o    = row_q;
  assign addr_o   = addr_q;
  assign last_c_o = col_wrap_c && (row_q == (h_i - Y_W'(1)));

endmodule

// File: rtl/sprite_draw_engine.sv
// Rectangle draw engine: walks a request row-major, fetches ROM colours and drives VGA plots.
module sprite_draw_engine
  import sprite_draw_engine_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [X_W-1:0]     req_x0,
  input  logic [Y_W-1:0]     req_y0,
  input  logic [X_W-1:0]     req_w,
  input  logic [Y_W-1:0]     req_h,
  input  logic               req_black,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [COLOR_W-1:0] mem_data,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_colour,
  output logic               vga_plot,
  output logic               busy,
  output logic               done
);

  draw_state_e        state_q, state_d;
  draw_req_t          req_q, req_d;
  logic               pix_vld_q, pix_vld_d;
  logic [X_W-1:0]     vga_x_q, vga_x_d;
  logic [Y_W-1:0]     vga_y_q, vga_y_d;
  logic               plot_q, plot_d;
  logic [COLOR_W-1:0] colour_q, colour_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept_c, start_scan_c, scan_step_c, last_c;
  logic [X_W-1:0]     col;
  logic [Y_W-1:0]     row;
  logic [XS_W-1:0]    x_sum_c;
  logic [YS_W-1:0]    y_sum_c;
  logic [COLOR_W-1:0] colour_c;

  rect_scan_counter u_scan (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (start_scan_c),
    .step_i   (scan_step_c),
    .w_i      (req_q.w),
    .h_i      (req_q.h),
    .col_o    (col),
    .row_o    (row),
    .addr_o   (mem_addr),
    .last_c_o (last_c)
  );

  // Next state, request capture, fetch pipeline and clip/black colour selection.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    accept_c     = req_valid && (state_q == ST_IDLE);
    start_scan_c = 1'b0;
    scan_step_c  = 1'b0;
    x_sum_c      = XS_W'(req_q.x0) + XS_W'(col);
    y_sum_c      = YS_W'(req_q.y0) + YS_W'(row);
    pix_vld_d    = (state_q == ST_SCAN);
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    plot_d       = 1'b0;
    colour_c     = colour_q;
    if (pix_vld_q) begin
      colour_c = req_q.black ? '0 : mem_data;
    end
    colour_d = colour_c;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          req_d = '{x0: req_x0, y0: req_y0, w: req_w, h: req_h, black: req_black};
          if ((req_w != '0) && (req_h != '0)) begin
            state_d      = ST_SCAN;
            start_scan_c = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SCAN: begin
        vga_x_d = x_sum_c[X_W-1:0];
        vga_y_d = y_sum_c[Y_W-1:0];
        plot_d  = on_screen(x_sum_c, y_sum_c);
        if (last_c) begin
          state_d = ST_FLUSH;
        end else begin
          scan_step_c = 1'b1;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      pix_vld_q <= 1'b0;
      vga_x_q   <= '0;
      vga_y_q   <= '0;
      plot_q    <= 1'b0;
      colour_q  <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      pix_vld_q <= pix_vld_d;
      vga_x_q   <= vga_x_d;
      vga_y_q   <= vga_y_d;
      plot_q    <= plot_d;
      colour_q  <= colour_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign req_ready  = ready_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_plot   = plot_q;
  assign vga_colour = colour_c;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Self-checking bench for sprite_draw_engine: directed table, reset abort, random and full-screen draws.
module tb_sprite_draw_engine;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_x0;
  logic [6:0]  req_y0;
  logic [7:0]  req_w;
  logic [6:0]  req_h;
  logic        req_black;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        busy;
  logic        done;

  int checks;
  int errors;
  int rom_mode;

  sprite_draw_engine dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x0     (req_x0),
    .req_y0     (req_y0),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_black  (req_black),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rom_f(input int a);
    if (rom_mode == 0) return a % 8;
    return (a * 3 + a / 8) % 8;
  endfunction

  // One-cycle-latency ROM
  always_ff @(posedge clk) mem_data <= 3'(rom_f(int'(mem_addr)));

  task automatic chk(input string name, input int cyc, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic drive_req(input int x0, input int y0, input int w, input int h, input bit blk);
    req_valid = 1'b1;
    req_x0    = 8'(x0);
    req_y0    = 7'(y0);
    req_w     = 8'(w);
    req_h     = 7'(h);
    req_black = blk;
  endtask

  task automatic start_req(input int x0, input int y0, input int w, input int h, input bit blk);
    @(negedge clk);
    drive_req(x0, y0, w, h, blk);
    chk("ready_before_accept", 0, int'(req_ready), 1);
    @(posedge clk);
  endtask

  // Runs cycles 1..done+1 after an accept, checking against a pixel-list model of the request.
  task automatic check_draw(input int x0, input int y0, input int w, input int h, input bit blk,
                            input bit keep, input int nx0, input int ny0, input int nw, input int nh,
                            input bit nblk, output int plots, output int done_cyc);
    int n, d, k, ex, ey;
    bit ep;
    n = w * h;
    d = (n == 0) ? 1 : n + 2;
    plots = 0;
    done_cyc = -1;
    for (int c = 1; c <= d + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (keep) begin
          drive_req(nx0, ny0, nw, nh, nblk);
        end else begin
          req_valid = 1'b0;
          req_x0 = 8'($urandom);
          req_y0 = 7'($urandom);
          req_w = 8'($urandom);
          req_h = 7'($urandom);
          req_black = 1'($urandom);
        end
      end
      k = c - 2;
      ep = 1'b0;
      ex = 0;
      ey = 0;
      if (k >= 0 && k < n) begin
        ex = x0 + k % w;
        ey = y0 + k / w;
        ep = (ex < 160) && (ey < 120);
      end
      chk("vga_plot", c, int'(vga_plot), int'(ep));
      if (ep) begin
        chk("vga_x", c, int'(vga_x), ex);
        chk("vga_y", c, int'(vga_y), ey);
        chk("vga_colour", c, int'(vga_colour), blk ? 0 : rom_f(k));
      end
      if (n > 0) chk("mem_addr", c, int'(mem_addr), (c <= n) ? c - 1 : n - 1);
      chk("busy", c, int'(busy), int'(c <= d));
      chk("done", c, int'(done), int'(c == d));
      if (c == d + 1) chk("ready_after_done", c, int'(req_ready), 1);
      if (vga_plot) plots++;
      if (done && done_cyc < 0) done_cyc = c;
    end
  endtask

  typedef struct {
    int x0;
    int y0;
    int w;
    int h;
    bit blk;
    int exp_plots;
    int exp_done;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int plots, dc, rw, rh, rx, ry;
    bit rb;
    checks = 0;
    errors = 0;
    rom_mode = 0;
    reset = 1'b1;
    req_valid = 1'b0;
    req_x0 = '0;
    req_y0 = '0;
    req_w = '0;
    req_h = '0;
    req_black = 1'b0;

    vecs[0] = '{10, 5, 2, 2, 1'b0, 4, 6};
    vecs[1] = '{158, 0, 4, 1, 1'b0, 2, 6};
    vecs[2] = '{7, 7, 0, 5, 1'b0, 0, 1};
    vecs[3] = '{30, 40, 3, 3, 1'b1, 9, 11};
    vecs[4] = '{150, 115, 20, 10, 1'b0, 50, 202};
    vecs[5] = '{250, 0, 10, 1, 1'b0, 0, 12};
    vecs[6] = '{5, 0, 1, 1, 1'b0, 1, 3};
    vecs[7] = '{9, 9, 3, 0, 1'b0, 0, 1};

    #2;
    chk("rst_ready", 0, int'(req_ready), 1);
    chk("rst_plot", 0, int'(vga_plot), 0);
    chk("rst_busy", 0, int'(busy), 0);
    chk("rst_done", 0, int'(done), 0);
    chk("rst_addr", 0, int'(mem_addr), 0);
    chk("rst_x", 0, int'(vga_x), 0);
    chk("rst_colour", 0, int'(vga_colour), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      start_req(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].blk);
      check_draw(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].blk,
                 1'b0, 0, 0, 0, 0, 1'b0, plots, dc);
      chk("vec_plot_count", i, plots, vecs[i].exp_plots);
      chk("vec_done_cycle", i, dc, vecs[i].exp_done);
    end

    // Reset during a 4x4 draw abandons it with no done pulse
    start_req(20, 20, 4, 4, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
    end
    chk("pre_reset_plot", 3, int'(vga_plot), 1);
    chk("pre_reset_x", 3, int'(vga_x), 21);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_plot", 4, int'(vga_plot), 0);
    chk("abort_ready", 4, int'(req_ready), 1);
    chk("abort_busy", 4, int'(busy), 0);
    chk("abort_done", 4, int'(done), 0);
    chk("abort_addr", 4, int'(mem_addr), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_abort_done", c, int'(done), 0);
      chk("post_abort_plot", c, int'(vga_plot), 0);
    end
    start_req(12, 34, 1, 1, 1'b0);
    check_draw(12, 34, 1, 1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, plots, dc);
    chk("after_abort_plots", 0, plots, 1);

    // Randomized requests checked against the pixel-list model
    rom_mode = 1;
    for (int i = 0; i < 24; i++) begin
      rx = int'($urandom_range(0, 255));
      ry = int'($urandom_range(0, 127));
      rw = int'($urandom_range(0, 12));
      rh = int'($urandom_range(0, 8));
      rb = 1'($urandom);
      start_req(rx, ry, rw, rh, rb);
      check_draw(rx, ry, rw, rh, rb, 1'b0, 0, 0, 0, 0, 1'b0, plots, dc);
      chk("rand_done_cycle", i, dc, (rw * rh == 0) ? 1 : rw * rh + 2);
    end

    // Full screen with req_valid held: next request accepted straight after done
    rom_mode = 0;
    start_req(0, 0, 160, 120, 1'b0);
    check_draw(0, 0, 160, 120, 1'b0, 1'b1, 3, 4, 1, 1, 1'b0, plots, dc);
    chk("full_plots", 0, plots, 19200);
    chk("full_done_cycle", 0, dc, 19202);
    @(posedge clk);
    check_draw(3, 4, 1, 1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, plots, dc);
    chk("b2b_plots", 0, plots, 1);
    chk("b2b_done_cycle", 0, dc, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
